// File: rtl/apb_master.sv
// APB master: one command in, one APB transfer out, one response back.
// Slave wait states are bounded by TIMEOUT; the abort is flagged in the response.
module apb_master #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 1,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  state_t                r_state;
  logic [7:0]            r_wait;
  logic                  r_cmd_ready;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;
  logic                  r_rsp_to;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= S_IDLE;
      r_wait      <= '0;
      r_cmd_ready <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_to    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          // cmd_ready stays low for the first cycle after reset release
          if (r_cmd_ready && cmd_valid) begin
            r_state     <= S_SETUP;
            r_cmd_ready <= 1'b0;
            r_paddr     <= cmd_addr;
            r_pwrite    <= cmd_write;
            r_pwdata    <= cmd_write ? cmd_wdata : '0;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        S_SETUP: begin
          r_state <= S_ACCESS;
          r_wait  <= '0;
        end
        S_ACCESS: begin
          if (PREADY) begin
            r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
            r_rsp_err   <= PSLVERR;
            r_rsp_to    <= 1'b0;
            r_state     <= S_RESP;
          end else if (r_wait == LP_LAST) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_to    <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_pwdata    <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign PSEL        = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign PENABLE     = (r_state == S_ACCESS);
  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign rsp_valid   = (r_state == S_RESP);
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_to;

endmodule

// File: tb/tb_apb_master.sv
// Directed plus random transfers against a transfer-level reference model.
// The bench plays the APB slave and the requester.
module tb_apb_master;
  localparam int DW = 8;
  localparam int AW = 1;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA = '0;
  logic          PREADY = 1'b0;
  logic          PSLVERR = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  logic [AW-1:0] m_addr = '0;
  logic          m_wr = 1'b0;

  apb_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic noise();
    PREADY  = 1'($urandom);
    PSLVERR = 1'($urandom);
    PRDATA  = DW'($urandom);
  endtask

  // One full transfer. waits = PREADY-low ACCESS cycles the slave inserts.
  task automatic xfer(input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input int waits,
                      input logic [DW-1:0] rd, input logic se,
                      input int bp);
    int            exp_acc;
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] exp_wd;
    logic          exp_err;
    logic          exp_to;
    int            k;
    exp_wd = wr ? wd : '0;
    if (waits >= TO) begin
      exp_acc = TO;
      exp_rd  = '0;
      exp_err = 1'b1;
      exp_to  = 1'b1;
    end else begin
      exp_acc = waits + 1;
      exp_rd  = wr ? '0 : rd;
      exp_err = se;
      exp_to  = 1'b0;
    end
    @(negedge PCLK);
    chk("idle_cmd_ready", 32'(cmd_ready), 1);
    chk("idle_psel_pen", {PSEL, PENABLE}, 0);
    chk("idle_pwdata", PWDATA, 0);
    chk("idle_paddr", PADDR, m_addr);
    chk("idle_pwrite", 32'(PWRITE), m_wr);
    chk("idle_rsp_valid", 32'(rsp_valid), 0);
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = wd;
    noise();
    @(negedge PCLK);
    chk("setup_psel_pen", {PSEL, PENABLE}, 2'b10);
    chk("setup_paddr", PADDR, a);
    chk("setup_pwrite", 32'(PWRITE), wr);
    chk("setup_pwdata", PWDATA, exp_wd);
    chk("setup_cmd_ready", 32'(cmd_ready), 0);
    cmd_valid = 1'($urandom);
    cmd_write = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_wdata = DW'($urandom);
    noise();
    k = 0;
    @(negedge PCLK);
    while (PSEL && PENABLE && k < 300) begin
      chk("acc_paddr", PADDR, a);
      chk("acc_pwrite", 32'(PWRITE), wr);
      chk("acc_pwdata", PWDATA, exp_wd);
      chk("acc_cmd_ready", 32'(cmd_ready), 0);
      chk("acc_rsp_valid", 32'(rsp_valid), 0);
      PREADY  = (k == waits);
      PRDATA  = (k == waits) ? rd : DW'($urandom);
      PSLVERR = (k == waits) ? se : 1'($urandom);
      k++;
      @(negedge PCLK);
    end
    chk("access_cycles", 32'(k), 32'(exp_acc));
    for (int i = 0; i <= bp; i++) begin
      chk("resp_valid", 32'(rsp_valid), 1);
      chk("resp_psel_pen", {PSEL, PENABLE}, 0);
      chk("resp_cmd_ready", 32'(cmd_ready), 0);
      chk("resp_rdata", rsp_rdata, exp_rd);
      chk("resp_err", 32'(rsp_err), exp_err);
      chk("resp_timeout", 32'(rsp_timeout), exp_to);
      rsp_ready = (i == bp);
      cmd_valid = (i == bp) ? 1'b0 : 1'($urandom);
      noise();
      if (i < bp) @(negedge PCLK);
    end
    m_addr = a;
    m_wr   = wr;
  endtask

  initial begin
    repeat (2) @(negedge PCLK);
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_psel_pen", {PSEL, PENABLE}, 0);
    chk("rst_pwrite", 32'(PWRITE), 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_timeout}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    PRESETn = 1'b1;

    xfer(1'b1, 1'b0, 8'hA5, 0, 8'h00, 1'b0, 0);
    xfer(1'b0, 1'b1, 8'h77, 3, 8'h3C, 1'b0, 0);
    xfer(1'b0, 1'b1, 8'h00, 0, 8'h5A, 1'b1, 1);
    xfer(1'b0, 1'b1, 8'h00, 100, 8'h99, 1'b0, 0);
    xfer(1'b0, 1'b0, 8'h00, TO - 1, 8'hC3, 1'b0, 0);
    xfer(1'b1, 1'b1, 8'h3E, TO + 3, 8'h11, 1'b1, 2);
    xfer(1'b0, 1'b1, 8'h00, 1, 8'hE7, 1'b0, 5);

    // abandon a read in the middle of its wait states
    @(negedge PCLK);
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 1'b1;
    PREADY    = 1'b0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("mid_access_pen", {PSEL, PENABLE}, 2'b11);
    #2 PRESETn = 1'b0;
    #1;
    chk("arst_psel_pen", {PSEL, PENABLE}, 0);
    chk("arst_cmd_ready", 32'(cmd_ready), 0);
    chk("arst_rsp_valid", 32'(rsp_valid), 0);
    chk("arst_paddr", PADDR, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    PREADY  = 1'b1;
    m_addr  = '0;
    m_wr    = 1'b0;
    repeat (3) begin
      @(negedge PCLK);
      chk("post_rst_rsp_valid", 32'(rsp_valid), 0);
      chk("post_rst_psel", 32'(PSEL), 0);
    end
    xfer(1'b1, 1'b1, 8'h42, 2, 8'h00, 1'b0, 0);

    for (int n = 0; n < 24; n++) begin
      int w;
      w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 2, TO + 4))
                                      : int'($urandom_range(0, 4));
      xfer(1'($urandom), AW'($urandom), DW'($urandom), w,
           DW'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end
    @(negedge PCLK);
    rsp_ready = 1'b0;
    @(negedge PCLK);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
